tff_toggle_sched: RTL and testbench
===================================

// Module: tff_toggle_sched
//
// PURPOSE
//  Round-robin scheduler that shares one bank of WIDTH T flip-flops (tff cells) among NREQ
//  requesters. Each requester posts a toggle mask. The block grants one requester at a time,
//  drives the bank's t inputs with that mask for exactly one cycle, then acks the requester.
//  Sits between client logic and the tff bank; q_in is the bank's q feedback.
//
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  WIDTH  8  number of T flip-flops in the shared bank
//
// PORTS
//  clk       in   1           rising-edge clock
//  rst       in   1           asynchronous reset, ACTIVE-LOW (0 = reset)
//  req       in   NREQ        req[i]=1: requester i wants a toggle; hold until ack[i]
//  mask      in   NREQ*WIDTH  mask[i*WIDTH +: WIDTH] = bits requester i wants toggled
//  t_out     out  WIDTH       to bank t inputs; nonzero only in TOGGLE
//  ack       out  NREQ        one-cycle pulse to the granted requester
//  grant_id  out  $clog2(NREQ) index of the current/last granted requester
//  busy      out  1           1 whenever state != IDLE
//  q_in      in   WIDTH       bank q feedback (used only by CHECK option)
//
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, t_out=0, ack=0, grant_id=0, busy=0, rr_ptr=0, err=0.
//  - FSM is IDLE -> TOGGLE -> ACK -> IDLE. All outputs are registered.
//  - IDLE: if any req is high at edge n, pick the first high req scanning from rr_ptr upward
//    (wrapping NREQ-1 -> 0). Latch grant_id and the granted mask into mask_r. Go to TOGGLE.
//    If no req is high, stay in IDLE.
//  - TOGGLE (cycle n..n+1): t_out=mask_r. At edge n+1 the bank toggles. Go to ACK.
//  - ACK (cycle n+1..n+2): t_out=0; ack[grant_id]=1, all other ack bits 0. Set
//    rr_ptr=grant_id+1 (mod NREQ). Go to IDLE at edge n+2.
//  - Latency: req sampled at edge n -> toggle at edge n+1 -> ack visible n+1..n+2.
//    Peak throughput is 1 grant per 3 cycles.
//  - The requester drops req after sampling ack. The controller does not sample req in ACK,
//    so no double grant can occur.
//  - mask is captured at grant. Later changes to mask or req during TOGGLE/ACK are ignored.
//  - mask_r==0: the full sequence still runs and ack is still issued; no bit toggles.
//  - Simultaneous reqs: only one grant per sequence; losers keep waiting.
//    Fairness: every continuously asserted req is served within NREQ sequences.
//  - A req that drops before its grant is never granted and never acked.
//  - Reset mid-sequence: t_out and ack clear immediately and asynchronously. The pending
//    requester gets no ack and must re-request.
//
// CONFIGURATION
//  TFF_SCHED_CHECK_EN defined:
//    - Adds output port err (1 bit, sticky, reset 0) and a WIDTH-bit q_snap register.
//    - At grant (edge n), q_snap <= q_in.
//    - In ACK, if q_in != (q_snap ^ mask_r), err <= 1 and stays 1 until rst=0.
//  TFF_SCHED_CHECK_EN not defined:
//    - No err port and no q_snap register. q_in is unused.
//
// TESTING
//  1 Reset: rst=0 with req=4'b1111 -> t_out=0, ack=0, busy=0 throughout. Release rst;
//    the first grant goes to requester 0.
//  2 Single request: req[2]=1, mask2=8'hA5 -> t_out=8'hA5 for exactly 1 cycle, then
//    ack=4'b0100 for 1 cycle. Bank q goes from 8'h00 to 8'hA5.
//  3 Round-robin: req=4'b1111 held, all masks 8'h01 -> grant_id order 0,1,2,3,0.
//    Each ack is spaced 3 cycles apart. Bank q bit0 alternates 1,0,1,0,1.
//  4 Zero mask / capture: req[1] with mask1=8'h00 -> ack issued, q unchanged.
//    Then req[1] with mask 8'h0F changed to 8'hF0 during TOGGLE -> toggles 8'h0F only.
//  5 Reset mid-op: assert rst=0 during TOGGLE -> t_out drops to 0 within the same cycle,
//    no ack is issued. After release, a held req[3] is granted (rr_ptr=0 scan reaches 3).
//  6 CHECK_EN: force q_in stuck at 8'h00 with mask 8'h3C -> err=1 in the cycle after ACK
//    and stays 1 until rst=0.
//    Without CHECK_EN: the same stimulus shows normal acks and no err port exists.

Source files
------------

// File: rtl/tff_toggle_sched_if.sv
// Bus between the T-flip-flop bank scheduler and its clients/bank.
// The master side is the scheduler; the slave side is the client logic
// plus the bank's q feedback.
// Optional build macro: TFF_SCHED_CHECK_EN adds the sticky err signal.
interface tff_toggle_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] mask;
  logic [WIDTH-1:0]      t_out;
  logic [NREQ-1:0]       ack;
  logic [IDW-1:0]        grant_id;
  logic                  busy;
  logic [WIDTH-1:0]      q_in;
`ifdef TFF_SCHED_CHECK_EN
  logic                  err;
`endif

`ifdef TFF_SCHED_CHECK_EN
  modport master (
    input  req, mask, q_in,
    output t_out, ack, grant_id, busy, err
  );

  modport slave (
    output req, mask, q_in,
    input  t_out, ack, grant_id, busy, err
  );
`else
  modport master (
    input  req, mask, q_in,
    output t_out, ack, grant_id, busy
  );

  modport slave (
    output req, mask, q_in,
    input  t_out, ack, grant_id, busy
  );
`endif

endinterface

// File: rtl/tff_toggle_sched.sv
// Round-robin scheduler sharing one bank of WIDTH T flip-flops among NREQ
// requesters. Each grant runs IDLE -> TOGGLE -> ACK: the captured mask is
// driven on t_out for one cycle, then the winner gets a one-cycle ack.
// All outputs are registered; rst is asynchronous and active-low.
// Optional build macro: TFF_SCHED_CHECK_EN snapshots q at grant and flags a
// sticky err if the bank did not end up at snapshot ^ mask.
module tff_toggle_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  tff_toggle_sched_if.master  bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int SW  = IDW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TOGGLE = 2'd1,
    ACK    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [WIDTH-1:0] t_out_q, t_out_d;
  logic [WIDTH-1:0] mask_r_q, mask_r_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             busy_q, busy_d;

  // Per-requester view of the flat mask bus.
  logic [WIDTH-1:0] mask_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_mask
    assign mask_a[i] = bus.mask[i*WIDTH +: WIDTH];
  end

  logic             pick_vld;
  logic [IDW-1:0]   pick_id;
  logic [WIDTH-1:0] pick_mask;
  logic [SW-1:0]    scan_sum;
  logic [IDW-1:0]   scan_idx;

  // Round-robin pick: first asserted req scanning up from rr_ptr, wrapping.
  always_comb begin
    pick_vld  = 1'b0;
    pick_id   = '0;
    pick_mask = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + SW'(k);
      if (scan_sum >= SW'(NREQ)) begin
        scan_sum = scan_sum - SW'(NREQ);
      end
      scan_idx = scan_sum[IDW-1:0];
      if (!pick_vld && bus.req[scan_idx]) begin
        pick_vld  = 1'b1;
        pick_id   = scan_idx;
        pick_mask = mask_a[scan_idx];
      end
    end
  end

  // Sequence FSM next state and registered-output next values.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    mask_r_d   = mask_r_q;
    t_out_d    = '0;
    ack_d      = '0;
    unique case (state_q)
      IDLE: begin
        // req is only looked at here, so later req/mask changes are ignored.
        if (pick_vld) begin
          state_d    = TOGGLE;
          grant_id_d = pick_id;
          mask_r_d   = pick_mask;
          t_out_d    = pick_mask;
        end
      end
      TOGGLE: begin
        state_d             = ACK;
        ack_d[grant_id_q]   = 1'b1;
      end
      ACK: begin
        state_d  = IDLE;
        rr_ptr_d = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control state and outputs; async reset clears t_out/ack immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      t_out_q    <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      t_out_q    <= t_out_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
    end
  end

  // Captured mask is pure data and is always rewritten at grant.
  always_ff @(posedge clk) begin
    mask_r_q <= mask_r_d;
  end

  assign bus.t_out    = t_out_q;
  assign bus.ack      = ack_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;

`ifdef TFF_SCHED_CHECK_EN
  logic [WIDTH-1:0] q_snap_q, q_snap_d;
  logic             err_q, err_d;

  // Snapshot at grant; in ACK the bank must read back snapshot ^ mask.
  always_comb begin
    q_snap_d = q_snap_q;
    err_d    = err_q;
    if (state_q == IDLE && pick_vld) begin
      q_snap_d = bus.q_in;
    end
    if (state_q == ACK && bus.q_in != (q_snap_q ^ mask_r_q)) begin
      err_d = 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  // Snapshot register is data and needs no reset.
  always_ff @(posedge clk) begin
    q_snap_q <= q_snap_d;
  end

  assign bus.err = err_q;
`else
  // Bank feedback only matters for the readback check.
  logic unused_q_in;
  assign unused_q_in = ^bus.q_in;
`endif

endmodule

// File: tb/tb_tff_toggle_sched.sv
// Directed bench for tff_toggle_sched: table of single-request transactions
// plus hand-written reset, round-robin, capture and readback sequences.
module tb_tff_toggle_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  tff_toggle_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  tff_toggle_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Bank model: T flip-flops toggling on t_out; q_in can be forced stuck.
  logic [WIDTH-1:0] bank_q = '0;
  logic             bank_clr = 1'b0;
  logic             stuck = 1'b0;

  always @(posedge clk) begin
    if (bank_clr) bank_q <= '0;
    else          bank_q <= bank_q ^ bus.t_out;
  end

  assign bus.q_in = stuck ? '0 : bank_q;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] mask;
    logic [1:0]  exp_gid;
    logic [7:0]  exp_t;
    logic [3:0]  exp_ack;
    logic [7:0]  exp_q;
  } vec_t;

  vec_t vecs [5];

  initial begin
    // Transactions applied back to back; rr_ptr and bank q carry over.
    vecs[0] = '{req: 4'b0100, mask: 32'h00A50000, exp_gid: 2'd2, exp_t: 8'hA5, exp_ack: 4'b0100, exp_q: 8'hA5};
    vecs[1] = '{req: 4'b0010, mask: 32'h00000000, exp_gid: 2'd1, exp_t: 8'h00, exp_ack: 4'b0010, exp_q: 8'hA5};
    vecs[2] = '{req: 4'b1010, mask: 32'h0F001100, exp_gid: 2'd3, exp_t: 8'h0F, exp_ack: 4'b1000, exp_q: 8'hAA};
    vecs[3] = '{req: 4'b1011, mask: 32'h000000F0, exp_gid: 2'd0, exp_t: 8'hF0, exp_ack: 4'b0001, exp_q: 8'h5A};
    vecs[4] = '{req: 4'b0001, mask: 32'h00000033, exp_gid: 2'd0, exp_t: 8'h33, exp_ack: 4'b0001, exp_q: 8'h69};

    bus.req  = 4'b1111;
    bus.mask = 32'h01010101;
    bank_clr = 1'b1;

    // Reset held with every requester asking.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_t_out", 32'(bus.t_out), 32'h0);
      chk("rst_ack", 32'(bus.ack), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_gid", 32'(bus.grant_id), 32'h0);
    end
`ifdef TFF_SCHED_CHECK_EN
    chk("rst_err", 32'(bus.err), 32'h0);
`endif
    bank_clr = 1'b0;
    rst = 1'b1;

    // Round robin with all requests held: grants 0,1,2,3,0, acks 3 cycles apart.
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("rr_gid", 32'(bus.grant_id), 32'(g % 4));
      chk("rr_t_out", 32'(bus.t_out), 32'h01);
      chk("rr_busy", 32'(bus.busy), 32'h1);
      tick();
      chk("rr_ack", 32'(bus.ack), 32'(4'b0001 << (g % 4)));
      chk("rr_q0", 32'(bank_q[0]), 32'((g % 2) == 0));
      chk("rr_t_zero", 32'(bus.t_out), 32'h0);
      if (g == 4) bus.req = 4'b0000;
      tick();
      chk("rr_ack_clr", 32'(bus.ack), 32'h0);
      chk("rr_idle", 32'(bus.busy), 32'h0);
    end

    bank_clr = 1'b1;
    tick();
    bank_clr = 1'b0;

    // Table-driven single transactions.
    for (int i = 0; i < 5; i++) begin
      bus.req  = vecs[i].req;
      bus.mask = vecs[i].mask;
      tick();
      chk("vec_gid", 32'(bus.grant_id), 32'(vecs[i].exp_gid));
      chk("vec_t_out", 32'(bus.t_out), 32'(vecs[i].exp_t));
      chk("vec_ack0", 32'(bus.ack), 32'h0);
      tick();
      chk("vec_ack", 32'(bus.ack), 32'(vecs[i].exp_ack));
      chk("vec_t_zero", 32'(bus.t_out), 32'h0);
      chk("vec_q", 32'(bank_q), 32'(vecs[i].exp_q));
      bus.req = 4'b0000;
      tick();
      chk("vec_ack_clr", 32'(bus.ack), 32'h0);
      chk("vec_idle", 32'(bus.busy), 32'h0);
    end

    // Mask captured at grant: change during TOGGLE must not leak.
    bus.req  = 4'b0010;
    bus.mask = 32'h00000F00;
    tick();
    chk("cap_t_out", 32'(bus.t_out), 32'h0F);
    bus.mask = 32'h0000F000;
    tick();
    chk("cap_ack", 32'(bus.ack), 32'b0010);
    chk("cap_q", 32'(bank_q), 32'h66);
    bus.req = 4'b0000;
    tick();
    chk("cap_idle", 32'(bus.busy), 32'h0);

    // Reset mid-TOGGLE: outputs clear asynchronously, no ack, then req[3] wins.
    bus.req  = 4'b1000;
    bus.mask = 32'hFF000000;
    tick();
    chk("mid_t_out", 32'(bus.t_out), 32'hFF);
    #2 rst = 1'b0;
    #1;
    chk("mid_t_clr", 32'(bus.t_out), 32'h0);
    chk("mid_busy_clr", 32'(bus.busy), 32'h0);
    tick();
    chk("mid_no_ack", 32'(bus.ack), 32'h0);
    rst = 1'b1;
    tick();
    chk("mid_regrant", 32'(bus.grant_id), 32'h3);
    chk("mid_regrant_t", 32'(bus.t_out), 32'hFF);
    tick();
    chk("mid_ack", 32'(bus.ack), 32'b1000);
    bus.req = 4'b0000;
    tick();

    // Readback check with q_in stuck at zero.
    stuck    = 1'b1;
    bus.req  = 4'b0001;
    bus.mask = 32'h0000003C;
    tick();
    chk("chk_t_out", 32'(bus.t_out), 32'h3C);
    tick();
    chk("chk_ack", 32'(bus.ack), 32'b0001);
    bus.req = 4'b0000;
    tick();
`ifdef TFF_SCHED_CHECK_EN
    chk("chk_err_set", 32'(bus.err), 32'h1);
    tick();
    tick();
    chk("chk_err_sticky", 32'(bus.err), 32'h1);
    rst = 1'b0;
    #1;
    chk("chk_err_rst", 32'(bus.err), 32'h0);
    rst = 1'b1;
`else
    chk("chk_idle", 32'(bus.busy), 32'h0);
`endif
    stuck = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
